// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
package loader_pkg;

    localparam int unsigned DEFAULT_DEPTH_WORDS = 1024;

    typedef enum logic [2:0] {
        LEN,
        DATA,
        CSUM,
        RUN,
        FAIL
    } loader_state_t;

    // States in which the loader is still consuming the byte stream.
    function automatic logic accepts_bytes(input loader_state_t s);
        return (s == LEN) || (s == DATA) || (s == CSUM);
    endfunction

endpackage

// File: rtl/byte2word.sv
// Little-endian byte-to-word assembler: lanes 0..2 are captured, lane 3
// completes the word combinationally so the caller sees it on the same edge.
module byte2word (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  byte_in,
    input  logic [3:0]  lane_en,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [23:0] low_q;
    logic [23:0] low_d;

    // Capture the lower three byte lanes as they arrive.
    always_comb begin
        low_d = low_q;
        if (lane_en[0]) low_d[7:0]   = byte_in;
        if (lane_en[1]) low_d[15:8]  = byte_in;
        if (lane_en[2]) low_d[23:16] = byte_in;
    end

    // Lane storage register.
    always_ff @(posedge clk) begin
        if (rst) begin
            low_q <= '0;
        end else begin
            low_q <= low_d;
        end
    end

    assign word       = {byte_in, low_q};
    assign word_valid = lane_en[3];

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed, checksummed image into instruction memory and
// releases the CPU only once the checksum has been verified.
module imem_loader
    import loader_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int unsigned ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              start,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              err
);

    loader_state_t     state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [31:0]       len_q, len_d;
    logic [31:0]       sum_q, sum_d;

    logic              in_ready_q, in_ready_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_waddr_q, imem_waddr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              accept;
    logic [3:0]        lane_en;
    logic [31:0]       word;
    logic              word_valid;
    logic              last_word;

    assign accept    = in_valid && in_ready_q;
    assign lane_en   = accept ? (4'b0001 << cnt_q) : 4'b0000;
    assign last_word = (32'(idx_q) == (len_q - 32'd1));

    byte2word u_b2w (
        .clk        (clk),
        .rst        (rst),
        .byte_in    (in_data),
        .lane_en    (lane_en),
        .word       (word),
        .word_valid (word_valid)
    );

    // State, datapath and output registers; reset returns to LEN with the CPU held.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= LEN;
            cnt_q        <= '0;
            idx_q        <= '0;
            len_q        <= '0;
            sum_q        <= '0;
            in_ready_q   <= 1'b1;
            imem_we_q    <= 1'b0;
            imem_waddr_q <= '0;
            imem_wdata_q <= '0;
            cpu_rst_q    <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            len_q        <= len_d;
            sum_q        <= sum_d;
            in_ready_q   <= in_ready_d;
            imem_we_q    <= imem_we_d;
            imem_waddr_q <= imem_waddr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_rst_q    <= cpu_rst_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    // Next-state and datapath update, driven by completed 32-bit fields.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        len_d   = len_q;
        sum_d   = sum_q;
        if (accept) cnt_d = cnt_q + 2'd1;
        case (state_q)
            LEN: begin
                if (word_valid) begin
                    len_d = word;
                    if (word == 32'd0)             state_d = CSUM;
                    else if (word > DEPTH_WORDS)   state_d = FAIL;
                    else                           state_d = DATA;
                end
            end
            DATA: begin
                if (word_valid) begin
                    sum_d = sum_q + word;
                    idx_d = idx_q + ADDR_W'(1);
                    if (last_word) state_d = CSUM;
                end
            end
            CSUM: begin
                if (word_valid) state_d = (word == sum_q) ? RUN : FAIL;
            end
            RUN, FAIL: begin
                if (start) begin
                    state_d = LEN;
                    cnt_d   = '0;
                    idx_d   = '0;
                    len_d   = '0;
                    sum_d   = '0;
                end
            end
            default: state_d = LEN;
        endcase
    end

    // Output decode from the upcoming state so every port comes from a flop.
    always_comb begin
        imem_we_d    = (state_q == DATA) && word_valid;
        imem_waddr_d = imem_we_d ? idx_q : imem_waddr_q;
        imem_wdata_d = imem_we_d ? word : imem_wdata_q;
        in_ready_d   = accepts_bytes(state_d);
        cpu_rst_d    = (state_d != RUN);
        done_d       = (state_d == RUN);
        err_d        = (state_d == FAIL);
    end

    assign in_ready   = in_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_waddr = imem_waddr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_rst    = cpu_rst_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomised bench for imem_loader: images are parsed by a simple stream
// model and the observed memory writes and final status are compared to it.
module tb_imem_loader;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        start;

    logic        ready_a, we_a, cpu_rst_a, done_a, err_a;
    logic [9:0]  waddr_a;
    logic [31:0] wdata_a;
    logic        ready_b, we_b, cpu_rst_b, done_b, err_b;
    logic [1:0]  waddr_b;
    logic [31:0] wdata_b;

    always #5 clk = ~clk;

    imem_loader dut_a (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (ready_a),
        .start      (start),
        .imem_we    (we_a),
        .imem_waddr (waddr_a),
        .imem_wdata (wdata_a),
        .cpu_rst    (cpu_rst_a),
        .done       (done_a),
        .err        (err_a)
    );

    imem_loader #(.DEPTH_WORDS(4)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (ready_b),
        .start      (start),
        .imem_we    (we_b),
        .imem_waddr (waddr_b),
        .imem_wdata (wdata_b),
        .cpu_rst    (cpu_rst_b),
        .done       (done_b),
        .err        (err_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Write monitors: {address, data} of every strobe seen.
    logic [63:0] obs_a[$];
    logic [63:0] obs_b[$];
    always @(negedge clk) begin
        if (we_a === 1'b1) obs_a.push_back({32'(waddr_a), wdata_a});
        if (we_b === 1'b1) obs_b.push_back({32'(waddr_b), wdata_b});
    end

    // Reference: parse the byte stream directly.
    logic [63:0] exp_w[$];
    int          exp_consumed;
    bit          exp_run;

    function automatic logic [31:0] le32(input bq_t b, input int o);
        return {b[o+3], b[o+2], b[o+1], b[o]};
    endfunction

    task automatic model(input bq_t b, input int unsigned depth);
        logic [31:0] n, sum, w, c;
        exp_w.delete();
        sum = '0;
        n = le32(b, 0);
        if (n > depth) begin
            exp_consumed = 4;
            exp_run = 1'b0;
            return;
        end
        for (int unsigned i = 0; i < n; i++) begin
            w = le32(b, 4 + 4 * int'(i));
            sum = sum + w;
            exp_w.push_back({32'(i), w});
        end
        c = le32(b, 4 + 4 * int'(n));
        exp_run = (c == sum);
        exp_consumed = 8 + 4 * int'(n);
    endtask

    task automatic build(input logic [31:0] n, input logic [31:0] words[$],
                         input logic [31:0] csum, output bq_t b);
        logic [31:0] v;
        b = {};
        v = n;
        for (int k = 0; k < 4; k++) b.push_back(v[8*k +: 8]);
        foreach (words[i]) begin
            v = words[i];
            for (int k = 0; k < 4; k++) b.push_back(v[8*k +: 8]);
        end
        v = csum;
        for (int k = 0; k < 4; k++) b.push_back(v[8*k +: 8]);
    endtask

    // Offer bytes while the selected DUT is ready; returns how many it took.
    task automatic drive(input int sel, input bq_t b, input bit gaps, input bit noise,
                         output int consumed);
        int budget;
        bit v;
        bit pending;
        consumed = 0;
        budget = 0;
        pending = 1'b0;
        while (consumed < b.size() && budget < 4000) begin
            @(negedge clk);
            budget++;
            pending = 1'b0;
            if (!(sel != 0 ? ready_b : ready_a)) break;
            v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_valid = v;
            in_data  = v ? b[consumed] : 8'($urandom);
            start    = noise && ($urandom_range(0, 7) == 0);
            if (v) consumed++;
            pending = 1'b1;
        end
        if (pending) @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic run_image(input int sel, input bq_t b, input bit gaps, input bit noise);
        bq_t b2;
        int  consumed;
        int  nobs;
        obs_a.delete();
        obs_b.delete();
        model(b, sel != 0 ? 4 : 1024);
        b2 = b;
        b2.push_back(8'h5A);
        b2.push_back(8'hC3);
        drive(sel, b2, gaps, noise, consumed);
        repeat (3) @(negedge clk);
        chk("bytes_accepted", 64'(consumed), 64'(exp_consumed));
        nobs = (sel != 0) ? obs_b.size() : obs_a.size();
        chk("write_count", 64'(nobs), 64'(exp_w.size()));
        for (int i = 0; i < nobs && i < exp_w.size(); i++)
            chk("write_addr_data", (sel != 0) ? obs_b[i] : obs_a[i], exp_w[i]);
        chk("done",     (sel != 0) ? done_b    : done_a,    exp_run);
        chk("err",      (sel != 0) ? err_b     : err_a,     !exp_run);
        chk("cpu_rst",  (sel != 0) ? cpu_rst_b : cpu_rst_a, !exp_run);
        chk("in_ready", (sel != 0) ? ready_b   : ready_a,   1'b0);
        chk("we_idle",  (sel != 0) ? we_b      : we_a,      1'b0);
    endtask

    task automatic rearm(input int sel);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("rearm_cpu_rst",  (sel != 0) ? cpu_rst_b : cpu_rst_a, 1'b1);
        chk("rearm_in_ready", (sel != 0) ? ready_b   : ready_a,   1'b1);
        chk("rearm_done",     (sel != 0) ? done_b    : done_a,    1'b0);
        chk("rearm_err",      (sel != 0) ? err_b     : err_a,     1'b0);
    endtask

    task automatic check_reset(input int sel);
        chk("rst_cpu_rst",  (sel != 0) ? cpu_rst_b : cpu_rst_a, 1'b1);
        chk("rst_in_ready", (sel != 0) ? ready_b   : ready_a,   1'b1);
        chk("rst_we",       (sel != 0) ? we_b      : we_a,      1'b0);
        chk("rst_waddr",    (sel != 0) ? 64'(waddr_b) : 64'(waddr_a), 64'd0);
        chk("rst_wdata",    (sel != 0) ? wdata_b   : wdata_a,   32'd0);
        chk("rst_done",     (sel != 0) ? done_b    : done_a,    1'b0);
        chk("rst_err",      (sel != 0) ? err_b     : err_a,     1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] wl[$];
        logic [31:0] sum;
        logic [31:0] n;
        bq_t good, img, part;
        int consumed;

        rst = 1'b1;
        in_valid = 1'b0;
        start = 1'b0;
        in_data = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_reset(0);
        check_reset(1);

        // Reference boot image: two words, correct checksum.
        wl = {};
        wl.push_back(32'h00000013);
        wl.push_back(32'h00100093);
        build(32'd2, wl, 32'h001000A6, good);
        run_image(0, good, 1'b0, 1'b0);
        rearm(0);
        run_image(0, good, 1'b0, 1'b0);
        rearm(0);

        // Empty image.
        wl = {};
        build(32'd0, wl, 32'h00000000, img);
        run_image(0, img, 1'b0, 1'b0);
        rearm(0);

        // Bad checksum: writes still happen, then FAIL.
        wl = {};
        wl.push_back(32'h00000013);
        wl.push_back(32'h00100093);
        build(32'd2, wl, 32'h001000A7, img);
        run_image(0, img, 1'b0, 1'b0);
        rearm(0);

        // Gapped stream, then reset in the middle of the data phase.
        run_image(0, good, 1'b1, 1'b0);
        rearm(0);
        obs_a.delete();
        part = {};
        for (int i = 0; i < 10; i++) part.push_back(good[i]);
        drive(0, part, 1'b1, 1'b0, consumed);
        for (int i = 0; i < 20 && obs_a.size() == 0; i++) @(negedge clk);
        chk("partial_writes", 64'(obs_a.size()), 64'd1);
        do_reset();
        check_reset(0);
        repeat (10) @(negedge clk);
        chk("no_write_after_rst", 64'(obs_a.size()), 64'd1);
        run_image(0, good, 1'b1, 1'b0);

        // Reset and start on the same edge: reset clears the write port too.
        @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        check_reset(0);

        // Random images, random gaps, start noise during loading.
        for (int it = 0; it < 30; it++) begin
            wl = {};
            sum = '0;
            n = 32'($urandom_range(0, 6));
            for (int unsigned i = 0; i < n; i++) begin
                wl.push_back($urandom);
                sum = sum + wl[wl.size() - 1];
            end
            if ($urandom_range(0, 2) == 0) sum = sum ^ (32'd1 << $urandom_range(0, 31));
            if (it % 10 == 9) begin
                n = 32'd1025 + 32'($urandom_range(0, 100000));
                wl = {};
            end
            build(n, wl, sum, img);
            run_image(0, img, 1'($urandom_range(0, 1)), 1'b1);
            rearm(0);
        end

        // Small-depth instance: oversize header fails immediately.
        do_reset();
        check_reset(1);
        wl = {};
        for (int i = 1; i <= 5; i++) wl.push_back(32'(i));
        build(32'd5, wl, 32'd15, img);
        run_image(1, img, 1'b0, 1'b0);
        rearm(1);
        wl = {};
        sum = '0;
        for (int i = 0; i < 4; i++) begin
            wl.push_back($urandom);
            sum = sum + wl[i];
        end
        build(32'd4, wl, sum, img);
        run_image(1, img, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, giving instruction-memory capacity in 32-bit words.
REQ-002 SHALL have parameter ADDR_W, default $clog2(DEPTH_WORDS), giving the word-address width.
REQ-003 SHALL use one clock with a synchronous, active-high reset: clk (input, 1) is the only clock, rising edge; rst (input, 1) is the synchronous active-high reset.
REQ-004 in_data  input  8  stream byte.
REQ-005 in_valid  input  1  in_data valid.
REQ-006 in_ready  output  1  loader accepts byte.
REQ-007 start  input  1  single-cycle re-arm request.
REQ-008 imem_we  output  1  instruction-memory write strobe.
REQ-009 imem_waddr  output  ADDR_W  word address.
REQ-010 imem_wdata  output  32  instruction word.
REQ-011 cpu_rst  output  1  active-high hold of the downstream CPU.
REQ-012 done  output  1  image loaded and verified.
REQ-013 err  output  1  load failed.

Function
REQ-014 A byte SHALL transfer on a rising clk edge where in_valid and in_ready are both 1; in_data is ignored otherwise.
REQ-015 The stream format SHALL be: 4-byte word count N; then N words of 4 bytes each; then a 4-byte checksum. All fields are little-endian, first byte is [7:0].
REQ-016 FSM states SHALL be LEN, DATA, CSUM, RUN and FAIL.
REQ-017 in_ready SHALL be 1 in LEN, DATA and CSUM, and 0 in RUN and FAIL.
REQ-018 A 2-bit byte counter SHALL select the byte lane and wrap 3->0 on each accepted 4th byte.
REQ-019 LEN: on the 4th byte, N=0 -> CSUM; N>DEPTH_WORDS -> FAIL; else -> DATA.
REQ-020 DATA: on each 4th byte, imem_we SHALL be 1 for exactly the following cycle, with imem_waddr = word index (starting at 0) and imem_wdata = assembled word.
REQ-021 DATA: the word index SHALL increment after each write; after word N-1 the state SHALL go to CSUM.
REQ-022 The checksum SHALL be the 32-bit modular sum of all N data words, accumulated as each word completes.
REQ-023 CSUM: on the 4th byte, a match with the running sum -> RUN; a mismatch -> FAIL.
REQ-024 cpu_rst SHALL be 1 in every state except RUN, and SHALL fall on the clock edge that enters RUN.
REQ-025 done SHALL be 1 only in RUN; err SHALL be 1 only in FAIL.
REQ-026 imem_we SHALL be 0 outside the write cycles of REQ-020.
REQ-027 start SHALL be honoured only in RUN or FAIL. It moves the FSM to LEN, clears counters, the sum and the word index, and sets cpu_rst=1 on the next edge.
REQ-028 start SHALL be ignored in LEN, DATA and CSUM.
REQ-029 in_valid gaps of any length between bytes SHALL NOT alter results.
REQ-030 If rst and start are both 1 on the same edge, rst SHALL win.

Reset
REQ-031 On rst the FSM SHALL enter LEN with these outputs: cpu_rst=1, in_ready=1, imem_we=0, imem_waddr=0, imem_wdata=0, done=0, err=0. Byte counter, word index and sum SHALL be 0.
REQ-032 rst asserted mid-DATA SHALL abort the load with no further imem writes. The partially written memory is left as-is.

Structure
REQ-033 A shared package loader_pkg SHALL hold the state enum loader_state_t and the constant DEFAULT_DEPTH_WORDS=1024.
REQ-034 Little-endian byte-to-word assembly SHALL be the sub-module byte2word: inputs byte plus lane-enable; outputs word plus word_valid.
REQ-035 All outputs SHALL be registered.

Verification
REQ-036 Reset, then stream N=2, words 0x00000013 and 0x00100093, checksum 0x001000A6 -> imem_we pulses at addr 0 then addr 1 with those data; cpu_rst falls; done=1.
REQ-037 Stream N=0 with checksum 0x00000000 -> no imem_we; RUN entered after the 8th byte.
REQ-038 Same image as REQ-036 with checksum 0x001000A7 -> FAIL; err=1; cpu_rst stays 1; in_ready=0; two writes occurred.
REQ-039 With DEPTH_WORDS=4, stream N=5 -> FAIL on the edge of the 4th header byte; no imem_we.
REQ-040 REQ-036 image with in_valid toggling every other cycle, plus rst asserted after the first data word -> first run identical to REQ-036; after rst, LEN with index 0 and no further writes.
REQ-041 Pulse start in RUN -> cpu_rst=1 and in_ready=1 next cycle; a reload of REQ-036 succeeds again.
